// File: rtl/sonar_mmio_bridge_pkg.sv
// Shared definitions for the sonar MMIO bridge: register offsets, channel
// state encoding and the read-select encoding of the bridge pipeline.
package sonar_mmio_pkg;

    localparam logic [11:0] OFF_LED         = 12'h000;
    localparam logic [11:0] OFF_STATUS      = 12'h001;
    localparam logic [11:0] OFF_TRIGGER     = 12'h002;
    localparam logic [11:0] OFF_RESULT_BASE = 12'h010;

    typedef enum logic [1:0] {
        IDLE,
        TRIG,
        WAIT,
        MEAS
    } ch_state_t;

    // Which source drives q_dmem in the cycle after the address was presented.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_MMIO
    } rd_sel_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sonar_mmio_bridge_if.sv
// Processor data-memory port as seen by the bridge: word address, write
// data, write enable and the 1-cycle-latency read data.
interface sonar_mmio_bridge_if;

    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;

    modport master (
        output address_dmem,
        output data,
        output wren,
        input  q_dmem
    );

    modport slave (
        input  address_dmem,
        input  data,
        input  wren,
        output q_dmem
    );

endinterface

// File: rtl/sonar_mmio_bridge_channel.sv
// One ultrasonic ranging channel: echo synchroniser, trigger/measure FSM,
// width counter, latched result and its valid flag.
module sonar_channel
    import sonar_mmio_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int TRIG_CYCLES = 1000,
    parameter int TIMEOUT     = 2_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             rd_clr,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] result
);

    // Counter must hold the timeout, the trigger length and the saturated width.
    localparam int CW = max_int(CNT_W,
                                max_int($clog2(TIMEOUT + 1), $clog2(TRIG_CYCLES + 1)));

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'({CNT_W{1'b1}});

    ch_state_t     state;
    logic [CW-1:0] cnt;
    logic [1:0]    sync;
    logic          echo_s;

    assign echo_s = sync[1];
    assign busy   = (state != IDLE);

    // Echo synchroniser, channel FSM, counter, result and valid in one process.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync   <= '0;
            state  <= IDLE;
            cnt    <= '0;
            trig   <= 1'b0;
            result <= '0;
            valid  <= 1'b0;
        end else begin
            sync <= {sync[0], echo};

            // A completion assigned below overrides this clear in the same cycle.
            if (rd_clr) begin
                valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    trig <= 1'b0;
                    if (start) begin
                        cnt   <= '0;
                        trig  <= 1'b1;
                        state <= TRIG;
                    end
                end
                TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        cnt   <= '0;
                        trig  <= 1'b0;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    trig <= 1'b0;
                    if (echo_s) begin
                        cnt   <= CW'(1);
                        state <= MEAS;
                    end else if (cnt == WAIT_LAST) begin
                        result <= '1;
                        valid  <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MEAS: begin
                    trig <= 1'b0;
                    if (!echo_s) begin
                        result <= cnt[CNT_W-1:0];
                        valid  <= 1'b1;
                        state  <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        result <= '1;
                        valid  <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    trig  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/sonar_mmio_bridge.sv
// Data-memory bridge: routes processor accesses either to the data RAM or
// to a single MMIO page holding the LED register and the sonar channels.
module sonar_mmio_bridge
    import sonar_mmio_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          LED_W       = 16,
    parameter int          CNT_W       = 24,
    parameter int          TRIG_CYCLES = 1000,
    parameter int          TIMEOUT     = 2_000_000,
    parameter logic [19:0] MMIO_PAGE   = 20'h00001
) (
    input  logic                 clock,
    input  logic                 reset,
    sonar_mmio_bridge_if.slave   dmem,
    output logic [11:0]          ram_addr,
    output logic                 ram_wEn,
    output logic [31:0]          ram_dataIn,
    input  logic [31:0]          ram_dataOut,
    output logic [NUM_CH-1:0]    trig,
    input  logic [NUM_CH-1:0]    echo,
    output logic [LED_W-1:0]     led
);

    logic              mmio;
    logic [11:0]       off;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] rd_clr;
    logic [NUM_CH-1:0] valid;
    logic [NUM_CH-1:0] busy;
    logic [CNT_W-1:0]  result [NUM_CH];
    logic [31:0]       rdata;
    logic [31:0]       rdata_q;
    rd_sel_t           sel;

    assign mmio       = (dmem.address_dmem[31:12] == MMIO_PAGE);
    assign off        = dmem.address_dmem[11:0];
    assign ram_addr   = off;
    assign ram_wEn    = dmem.wren & ~mmio;
    assign ram_dataIn = dmem.data;

    // Trigger register write fans out one start request per channel.
    always_comb begin
        start = '0;
        if (mmio && dmem.wren && (off == OFF_TRIGGER)) begin
            start = dmem.data[NUM_CH-1:0];
        end
    end

    // MMIO read mux and the result-read strobes that clear valid.
    always_comb begin
        rdata  = '0;
        rd_clr = '0;
        if (off == OFF_LED) begin
            rdata = 32'(led);
        end else if (off == OFF_STATUS) begin
            rdata = {16'(busy), 16'(valid)};
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (off == (OFF_RESULT_BASE + 12'(i))) begin
                rdata     = 32'(result[i]);
                rd_clr[i] = mmio & ~dmem.wren;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sonar_channel #(
            .CNT_W       (CNT_W),
            .TRIG_CYCLES (TRIG_CYCLES),
            .TIMEOUT     (TIMEOUT)
        ) u_ch (
            .clock  (clock),
            .reset  (reset),
            .start  (start[g]),
            .rd_clr (rd_clr[g]),
            .echo   (echo[g]),
            .trig   (trig[g]),
            .busy   (busy[g]),
            .valid  (valid[g]),
            .result (result[g])
        );
    end

    // LED register.
    always_ff @(posedge clock) begin
        if (reset) begin
            led <= '0;
        end else if (mmio && dmem.wren && (off == OFF_LED)) begin
            led <= dmem.data[LED_W-1:0];
        end
    end

    // Read pipeline: registered source select and MMIO read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel     <= SEL_NONE;
            rdata_q <= '0;
        end else begin
            sel     <= mmio ? SEL_MMIO : SEL_RAM;
            rdata_q <= rdata;
        end
    end

    // Return path: RAM data already carries its own 1-cycle latency.
    always_comb begin
        case (sel)
            SEL_MMIO: dmem.q_dmem = rdata_q;
            SEL_RAM:  dmem.q_dmem = ram_dataOut;
            default:  dmem.q_dmem = '0;
        endcase
    end

endmodule

// File: tb/tb_sonar_mmio_bridge.sv
// Scoreboard bench: two bridges (24-bit and 8-bit result width) receive the
// same bus and echo stimulus; reads push expectations checked by a monitor.
module tb_sonar_mmio_bridge;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sonar_mmio_bridge_if bus_a ();
    sonar_mmio_bridge_if bus_b ();

    assign bus_b.address_dmem = bus_a.address_dmem;
    assign bus_b.data         = bus_a.data;
    assign bus_b.wren         = bus_a.wren;

    logic [11:0] ram_addr_a, ram_addr_b;
    logic        ram_wEn_a, ram_wEn_b;
    logic [31:0] ram_dataIn_a, ram_dataIn_b;
    logic [31:0] ram_q_a, ram_q_b;
    logic [1:0]  trig_a, trig_b;
    logic [1:0]  echo = 2'b00;
    logic [15:0] led_a, led_b;

    sonar_mmio_bridge #(
        .NUM_CH(2), .LED_W(16), .CNT_W(24), .TRIG_CYCLES(10), .TIMEOUT(100),
        .MMIO_PAGE(20'h00001)
    ) dut_a (
        .clock(clock), .reset(reset), .dmem(bus_a),
        .ram_addr(ram_addr_a), .ram_wEn(ram_wEn_a), .ram_dataIn(ram_dataIn_a),
        .ram_dataOut(ram_q_a), .trig(trig_a), .echo(echo), .led(led_a)
    );

    sonar_mmio_bridge #(
        .NUM_CH(2), .LED_W(16), .CNT_W(8), .TRIG_CYCLES(10), .TIMEOUT(100),
        .MMIO_PAGE(20'h00001)
    ) dut_b (
        .clock(clock), .reset(reset), .dmem(bus_b),
        .ram_addr(ram_addr_b), .ram_wEn(ram_wEn_b), .ram_dataIn(ram_dataIn_b),
        .ram_dataOut(ram_q_b), .trig(trig_b), .echo(echo), .led(led_b)
    );

    // Behavioural RAMs with registered read.
    logic [31:0] mem_a [4096];
    logic [31:0] mem_b [4096];
    always @(posedge clock) begin
        if (ram_wEn_a) mem_a[ram_addr_a] <= ram_dataIn_a;
        ram_q_a <= mem_a[ram_addr_a];
        if (ram_wEn_b) mem_b[ram_addr_b] <= ram_dataIn_b;
        ram_q_b <= mem_b[ram_addr_b];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] lo, input logic [31:0] hi);
        tests++;
        if ((act < lo) || (act > hi)) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h..0x%08h", name, act, lo, hi);
        end
    endtask

    // ---------------- scoreboard + read monitor ----------------
    typedef struct {
        string       name;
        logic [31:0] lo_a;
        logic [31:0] hi_a;
        logic [31:0] lo_b;
        logic [31:0] hi_b;
    } exp_t;

    exp_t sb[$];
    logic rd_issue = 1'b0;
    logic rd_d = 1'b0;

    always @(posedge clock) rd_d <= rd_issue;

    always @(negedge clock) begin
        exp_t e;
        if (rd_d) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: got a read with no expectation queued");
            end else begin
                e = sb.pop_front();
                check({e.name, "_a"}, bus_a.q_dmem, e.lo_a, e.hi_a);
                check({e.name, "_b"}, bus_b.q_dmem, e.lo_b, e.hi_b);
            end
        end
    end

    // ---------------- trigger pulse monitor ----------------
    int unsigned tq [4][$];
    int unsigned run [4] = '{default: 0};

    always @(negedge clock) begin
        logic [3:0]  t;
        int unsigned w;
        t = {trig_b, trig_a};
        for (int i = 0; i < 4; i++) begin
            if (t[i]) begin
                run[i]++;
            end else if (run[i] != 0) begin
                if (tq[i].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL trig%0d_unexpected: got pulse of %0d, required none", i, run[i]);
                end else begin
                    w = tq[i].pop_front();
                    check($sformatf("trig%0d_width", i), run[i], w, w);
                end
                run[i] = 0;
            end
        end
    end

    // ---------------- RAM write-enable monitor ----------------
    int wen_cnt_a = 0;
    int wen_cnt_b = 0;
    always @(negedge clock) begin
        if (ram_wEn_a === 1'b1) wen_cnt_a++;
        if (ram_wEn_b === 1'b1) wen_cnt_b++;
    end

    // ---------------- reference model state ----------------
    logic [31:0] exp_mem [int];
    logic [31:0] led_m = '0;
    logic [1:0]  valid_m = '0;
    logic [31:0] res_lo_a [2] = '{default: 0};
    logic [31:0] res_hi_a [2] = '{default: 0};
    logic [31:0] res_lo_b [2] = '{default: 0};
    logic [31:0] res_hi_b [2] = '{default: 0};
    int          exp_wen = 0;

    function automatic logic [31:0] mm(input logic [11:0] o);
        return {20'h00001, o};
    endfunction

    function automatic logic [31:0] sat(input int v, input int w);
        int maxv;
        maxv = (1 << w) - 1;
        if (v < 0) return 0;
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic logic [31:0] stat(input logic [1:0] busy);
        return {14'd0, busy, 14'd0, valid_m};
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic we);
        @(posedge clock);
        #1;
        bus_a.address_dmem = a;
        bus_a.data         = d;
        bus_a.wren         = we;
        rd_issue           = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) op(32'h0, $urandom, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] lo_a, input logic [31:0] hi_a,
                      input logic [31:0] lo_b, input logic [31:0] hi_b, input string name);
        exp_t e;
        op(a, $urandom, 1'b0);
        rd_issue = 1'b1;
        e.name = name; e.lo_a = lo_a; e.hi_a = hi_a; e.lo_b = lo_b; e.hi_b = hi_b;
        sb.push_back(e);
    endtask

    task automatic rd1(input logic [31:0] a, input logic [31:0] v, input string name);
        rd(a, v, v, v, v, name);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [19:0] page;
        logic [11:0] o;
        page = a[31:12];
        o    = a[11:0];
        op(a, d, 1'b1);
        if (page != 20'h00001) begin
            exp_wen++;
            exp_mem[int'(o)] = d;
        end else if (o == 12'h000) begin
            led_m = {16'h0, d[15:0]};
        end
    endtask

    task automatic rd_result(input int ch);
        rd(mm(12'h010 + 12'(ch)), res_lo_a[ch], res_hi_a[ch], res_lo_b[ch], res_hi_b[ch],
           $sformatf("result%0d", ch));
        valid_m[ch] = 1'b0;
    endtask

    task automatic set_done(input int ch, input int h);
        valid_m[ch]  = 1'b1;
        res_lo_a[ch] = sat(h - 1, 24);
        res_hi_a[ch] = sat(h + 1, 24);
        res_lo_b[ch] = sat(h - 1, 8);
        res_hi_b[ch] = sat(h + 1, 8);
    endtask

    task automatic set_timeout(input int ch);
        valid_m[ch]  = 1'b1;
        res_lo_a[ch] = 32'h00FF_FFFF;
        res_hi_a[ch] = 32'h00FF_FFFF;
        res_lo_b[ch] = 32'h0000_00FF;
        res_hi_b[ch] = 32'h0000_00FF;
    endtask

    task automatic push_trig(input int ch, input int unsigned w);
        tq[ch].push_back(w);
        tq[ch + 2].push_back(w);
    endtask

    // Full ranging cycle on one channel with an echo of h clocks.
    task automatic meas(input int ch, input int h, input bit do_read);
        logic [31:0] d;
        logic [1:0]  b;
        d = (32'h1 << ch) | ($urandom & 32'hFFFF_FFFC);
        b = 2'(1 << ch);
        wr(mm(12'h002), d);
        push_trig(ch, 10);
        idle(12);
        rd1(mm(12'h001), stat(b), "status_wait");
        echo[ch] = 1'b1;
        idle(5);
        rd1(mm(12'h001), stat(b), "status_meas");
        idle(h - 6);
        echo[ch] = 1'b0;
        idle(5);
        set_done(ch, h);
        rd1(mm(12'h001), stat(2'b00), "status_done");
        if (do_read) begin
            rd_result(ch);
            rd1(mm(12'h001), stat(2'b00), "status_cleared");
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] v;
        int          h;
        int          ch;

        bus_a.address_dmem = '0;
        bus_a.data         = '0;
        bus_a.wren         = 1'b0;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        check("rst_q_dmem", bus_a.q_dmem, 0, 0);
        check("rst_led", 32'(led_a), 0, 0);
        check("rst_trig", 32'({trig_b, trig_a}), 0, 0);
        reset = 1'b0;
        rd1(mm(12'h001), 32'h0, "rst_status");
        rd_result(0);
        rd_result(1);

        // LED register: fixed pattern, upper-bit masking, then random values.
        wr(mm(12'h000), 32'h0000_00A5);
        rd1(mm(12'h000), led_m, "led_a5");
        check("led_port", 32'(led_a), 32'h00A5, 32'h00A5);
        wr(mm(12'h000), 32'hFFFF_FFFF);
        rd1(mm(12'h000), 32'h0000_FFFF, "led_mask");
        for (int i = 0; i < 3; i++) begin
            wr(mm(12'h000), $urandom);
            rd1(mm(12'h000), led_m, "led_rand");
        end

        // RAM path.
        wr(32'h0000_0004, 32'h1234_5678);
        rd1(32'h0000_0004, 32'h1234_5678, "ram_fixed");
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            if (a[31:12] == 20'h00001) a[31] = 1'b1;
            v = $urandom;
            wr(a, v);
            rd1(a, exp_mem[int'(a[11:0])], "ram_rand");
        end

        // Unmapped and write-only offsets.
        wr(mm(12'h003), $urandom);
        wr(mm(12'h001), 32'hFFFF_FFFF);
        rd1(mm(12'h003), 32'h0, "unmapped");
        rd1(mm(12'h012), 32'h0, "result_oob");
        rd1(mm(12'h002), 32'h0, "trigger_rd");
        rd1(mm(12'h001), stat(2'b00), "status_ro");

        // Channel 0 long echo: 24-bit measures it, 8-bit saturates.
        meas(0, $urandom_range(300, 600), 1'b1);

        // Channel 1 timeout, with triggers while busy that must be ignored.
        wr(mm(12'h002), 32'h2);
        push_trig(1, 10);
        wr(mm(12'h002), 32'h2);
        idle(3);
        wr(mm(12'h002), 32'h2);
        idle(94);
        rd1(mm(12'h001), stat(2'b10), "status_tmo_busy");
        idle(15);
        set_timeout(1);
        rd1(mm(12'h001), stat(2'b00), "status_tmo");
        rd_result(1);
        rd1(mm(12'h001), stat(2'b00), "status_tmo_clr");

        // 400-cycle echo kept unread, then a restart that keeps valid and a
        // result read landing on the timeout completion edge.
        meas(0, 400, 1'b0);
        wr(mm(12'h002), 32'h1);
        push_trig(0, 10);
        rd1(mm(12'h001), stat(2'b01), "status_restart");
        idle(108);
        rd(mm(12'h010), res_lo_a[0], res_hi_a[0], res_lo_b[0], res_hi_b[0], "result_collide");
        set_timeout(0);
        rd1(mm(12'h001), stat(2'b00), "status_collide");
        rd_result(0);
        rd1(mm(12'h001), stat(2'b00), "status_collide_clr");

        // Reset while channel 0 measures and channel 1 triggers.
        wr(mm(12'h002), 32'h1);
        push_trig(0, 10);
        idle(12);
        echo[0] = 1'b1;
        idle(20);
        wr(mm(12'h002), 32'h2);
        push_trig(1, 3);
        idle(2);
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus_a.address_dmem = '0;
        bus_a.wren         = 1'b0;
        rd_issue           = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        echo  = 2'b00;
        check("rst_mid_trig", 32'({trig_b, trig_a}), 0, 0);
        check("rst_mid_q_dmem", bus_a.q_dmem, 0, 0);
        valid_m = '0;
        led_m   = '0;
        for (int i = 0; i < 2; i++) begin
            res_lo_a[i] = '0; res_hi_a[i] = '0; res_lo_b[i] = '0; res_hi_b[i] = '0;
        end
        rd1(mm(12'h001), 32'h0, "rst_mid_status");
        rd_result(0);
        rd_result(1);
        rd1(mm(12'h000), 32'h0, "rst_mid_led");

        // Random traffic mixed with measurements.
        for (int i = 0; i < 4; i++) begin
            wr(mm(12'h000), $urandom);
            rd1(mm(12'h000), led_m, "led_mix");
            a = $urandom;
            if (a[31:12] == 20'h00001) a[31] = 1'b1;
            wr(a, $urandom);
            rd1(a, exp_mem[int'(a[11:0])], "ram_mix");
            ch = int'($urandom_range(0, 1));
            h  = int'($urandom_range(20, 300));
            meas(ch, h, 1'b1);
        end

        idle(5);
        check("sb_drained", 32'(sb.size()), 0, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("trig%0d_drained", i), 32'(tq[i].size()), 0, 0);
        end
        check("ram_wen_count_a", 32'(wen_cnt_a), 32'(exp_wen), 32'(exp_wen));
        check("ram_wen_count_b", 32'(wen_cnt_b), 32'(exp_wen), 32'(exp_wen));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sonar_mmio_bridge.md
# sonar_mmio_bridge

Data-memory-side bridge between the processor's `address_dmem`/`data`/`wren`/`q_dmem` port and the data RAM. It carves out one MMIO page for an LED register and `NUM_CH` independent ultrasonic ranging channels. Each channel generates a trigger pulse, measures the echo high time in clock cycles, and latches the result for the processor to read. It sits between the CPU core and the RAM instance in the top-level FPGA wrapper, in place of the direct CPU-to-RAM hookup.

## Interface
- `NUM_CH`, 2: number of sonar channels (1–16).
- `LED_W`, 16: LED register width (1–32).
- `CNT_W`, 24: width of the echo-width counter and the result.
- `TRIG_CYCLES`, 1000: trigger pulse length in clocks (10 µs at 100 MHz).
- `TIMEOUT`, 2_000_000: maximum clocks spent waiting for an echo rising edge.
- `MMIO_PAGE`, 20'h00001: value of `address_dmem[31:12]` that selects MMIO.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `address_dmem` in 32: processor word address.
- `data` in 32: processor write data.
- `wren` in 1: processor write enable.
- `q_dmem` out 32: read data returned to the processor.
- `ram_addr` out 12: equals `address_dmem[11:0]`.
- `ram_wEn` out 1: `wren` when the address is not in the MMIO page.
- `ram_dataIn` out 32: equals `data`.
- `ram_dataOut` in 32: RAM read data, registered, with 1-cycle latency.
- `trig` out NUM_CH: sonar trigger outputs.
- `echo` in NUM_CH: sonar echo inputs, asynchronous.
- `led` out LED_W: LED register.

## Operation
- Decode: `mmio = (address_dmem[31:12] == MMIO_PAGE)`. The MMIO offset is `address_dmem[11:0]`.
- Register map (word offsets):
  - 0x000 LED: read/write, low LED_W bits; upper read bits are 0.
  - 0x001 STATUS: read-only. Bit i = `valid[i]`; bit 16+i = `busy[i]`.
  - 0x002 TRIGGER: write-only, reads 0. A write with bit i set starts channel i if it is in IDLE; the request is ignored otherwise.
  - 0x010+i RESULT[i]: read-only, zero-extended to 32 bits. A read clears `valid[i]`.
  - All other offsets read 0 and ignore writes.
- Writes to MMIO never assert `ram_wEn`.
- `echo` passes through a 2-flop synchroniser per channel before use.
- Per-channel FSM, with a counter `cnt` of width max(CNT_W, clog2(TIMEOUT+1)):
  - IDLE: `trig`=0. On a start request: `cnt`←0, go to TRIG.
  - TRIG: `trig`=1. When `cnt`==TRIG_CYCLES-1: `cnt`←0, go to WAIT.
  - WAIT: `trig`=0.
    - Synchronised echo high: `cnt`←1, go to MEAS.
    - Else if `cnt`==TIMEOUT-1: result←all ones, `valid`←1, go to IDLE.
  - MEAS: `cnt` increments each cycle echo stays high.
    - Echo low: result←`cnt`, `valid`←1, go to IDLE.
    - `cnt` reaches 2^CNT_W-1: result←2^CNT_W-1 (saturated), `valid`←1, go to IDLE.
  - `busy[i]` = (state != IDLE).
- A new start does not clear `valid`. The result register holds its value until the next completion.
- Simultaneous RESULT[i] read and channel-i completion in the same cycle: the completion wins, so `valid[i]` stays 1 and the read returns the old result.
- Reset values:
  - `led`=0, `trig`=0, all channels IDLE, results=0, `valid`=0.
  - `q_dmem`=0, synchroniser flops=0.
  - Reset mid-measurement aborts the measurement; `trig` drops in the cycle after reset is sampled.

## Timing
- Read latency is 1 cycle for both RAM and MMIO. The bridge registers the `mmio` select and the MMIO read data. `q_dmem` in cycle n+1 = registered select ? MMIO data : `ram_dataOut`, for an address presented in cycle n.
- The valid-clear side effect of a read takes effect at the same edge that registers the read data.
- A TRIGGER write at edge n puts the channel in TRIG after edge n; `trig` is high for exactly TRIG_CYCLES cycles.
- Echo-to-FSM latency is 2 cycles. The measured width equals the echo high time in clocks, ±1.
- LED write at edge n: `led` updates after edge n.

## Structure
- Package `sonar_mmio_pkg` holds:
  - register offset constants (`OFF_LED`, `OFF_STATUS`, `OFF_TRIGGER`, `OFF_RESULT_BASE`);
  - the channel state enum {IDLE, TRIG, WAIT, MEAS}.
- Sub-module `sonar_channel` contains one FSM, counter, synchroniser, result and valid. It is instantiated NUM_CH times with a generate loop.
- The top level holds the decode, the LED register, and the read-mux pipeline register.

## Test plan
- Reset, then write 0xA5 to MMIO offset 0x000 -> `led`=0x00A5; a read the next cycle returns 0x000000A5; `ram_wEn` stays 0 throughout.
- RAM path: write 0x12345678 to address 0x004, then read it -> `q_dmem`=0x12345678 one cycle after the read address; `ram_wEn` pulses once.
- Ch0, TRIG_CYCLES=10: write 0x1 to TRIGGER -> `trig[0]` high 10 cycles. Drive echo high 500 cycles -> STATUS bit0=1. RESULT[0] reads 500±1, then STATUS bit0=0.
- Ch1 with echo held low, TIMEOUT=100 -> after 10+100 cycles `valid[1]`=1 and RESULT[1]=0xFFFFFF. A TRIGGER write while busy is ignored: exactly one pulse.
- CNT_W=8, echo high 400 cycles -> RESULT=255, `valid`=1, channel back in IDLE.
- Assert reset during MEAS -> `trig`=0, STATUS=0, RESULT=0 on the next read; a subsequent trigger runs a normal measurement.
